// File: rtl/isqrt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : isqrt_pkg
//  Description : Shared types and sizing helpers for the sequential integer
//                square-root unit (state encoding, root and counter widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package isqrt_pkg;

    // Controller states with a fixed 2-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Root width and iteration count for a given radicand width
    function automatic int root_width(input int width);
        return width / 2;
    endfunction

    // Iteration counter width: holds N-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/isqrt_step.sv
`default_nettype none
// ============================================================================
//  Module      : isqrt_step
//  Description : One purely combinational restoring square-root iteration.
//                Tries to append a '1' root bit by subtracting {root,01}
//                from {rem,bits}; keeps the shifted remainder on underflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module isqrt_step #(
    parameter int N = 4
) (
    input  logic [N+1:0] rem_in,
    input  logic [N-1:0] root_in,
    input  logic [1:0]   bits,
    output logic [N+1:0] rem_out,
    output logic [N-1:0] root_out
);

    logic [N+2:0] w_trial;
    logic [N+2:0] w_sub;
    logic [N+2:0] w_diff;
    logic         w_ge;
    logic         w_unused_rem_msb;

    // The working remainder never exceeds N+1 significant bits, so its MSB
    // can be dropped and the trial subtraction done in N+3 signed bits.
    assign w_unused_rem_msb = rem_in[N+1];

    // Trial subtraction and restore/accept selection
    always_comb begin
        w_trial = {rem_in[N:0], bits};
        w_sub   = {1'b0, root_in, 2'b01};
        w_diff  = w_trial - w_sub;
        w_ge    = ~w_diff[N+2];
        if (w_ge) begin
            rem_out  = w_diff[N+1:0];
            root_out = {root_in[N-2:0], 1'b1};
        end else begin
            rem_out  = w_trial[N+1:0];
            root_out = {root_in[N-2:0], 1'b0};
        end
    end

endmodule
`default_nettype wire

// File: rtl/isqrt_seq.sv
`default_nettype none
// ============================================================================
//  Module      : isqrt_seq
//  Description : Self-sequenced integer square root, one root bit per cycle,
//                with start/ready/done handshake. root = floor(sqrt(In)),
//                rem = In - root^2. All outputs are registered.
//                Optional feature macro: ISQRT_REMAINDER_EN (rem port).
//                WIDTH must be even and at least 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module isqrt_seq
    import isqrt_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               start,
    input  logic [WIDTH-1:0]   In,
    output logic               ready,
    output logic               done,
    output logic [WIDTH/2-1:0] root
`ifdef ISQRT_REMAINDER_EN
    ,
    output logic [WIDTH/2:0]   rem
`endif
);

    localparam int c_N  = root_width(WIDTH);
    localparam int c_CW = cnt_width(c_N);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_accept;
    logic            w_last;

    logic [WIDTH-1:0] r_rad;
    logic [c_N+1:0]   r_work_rem;
    logic [c_N-1:0]   r_work_root;
    logic [c_CW-1:0]  r_cnt;
    logic [c_N+1:0]   w_rem_nxt;
    logic [c_N-1:0]   w_root_nxt;

    logic             r_ready;
    logic             r_done;
    logic [c_N-1:0]   r_root;

    // Single iteration datapath, fed by the top two radicand bits
    isqrt_step #(
        .N (c_N)
    ) u_step (
        .rem_in   (r_work_rem),
        .root_in  (r_work_root),
        .bits     (r_rad[WIDTH-1:WIDTH-2]),
        .rem_out  (w_rem_nxt),
        .root_out (w_root_nxt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; acceptance only from IDLE, finish when counter hits 0
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_cnt == '0) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Working registers: load on acceptance, iterate every RUN cycle
    always_ff @(posedge clk) begin
        if (clear) begin
            r_rad       <= '0;
            r_work_rem  <= '0;
            r_work_root <= '0;
            r_cnt       <= '0;
        end else if (w_accept) begin
            r_rad       <= In;
            r_work_rem  <= '0;
            r_work_root <= '0;
            r_cnt       <= c_CW'(c_N - 1);
        end else if (r_state == ST_RUN) begin
            r_rad       <= {r_rad[WIDTH-3:0], 2'b00};
            r_work_rem  <= w_rem_nxt;
            r_work_root <= w_root_nxt;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - c_CW'(1);
            end
        end
    end

    // Handshake flags registered from the next state so outputs stay glitch-free
    always_ff @(posedge clk) begin
        if (clear) begin
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_ready <= (w_state_nxt == ST_IDLE);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    // Result root register, updated only on the final iteration
    always_ff @(posedge clk) begin
        if (clear) begin
            r_root <= '0;
        end else if (w_last) begin
            r_root <= w_root_nxt;
        end
    end

    assign ready = r_ready;
    assign done  = r_done;
    assign root  = r_root;

`ifdef ISQRT_REMAINDER_EN
    logic [c_N:0] r_rem;

    // Result remainder register; the final remainder always fits N+1 bits
    always_ff @(posedge clk) begin
        if (clear) begin
            r_rem <= '0;
        end else if (w_last) begin
            r_rem <= w_rem_nxt[c_N:0];
        end
    end

    assign rem = r_rem;
`endif

endmodule
`default_nettype wire

// File: tb/tb_isqrt_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_isqrt_seq
//  Description : Self-checking bench for isqrt_seq (WIDTH=8 and WIDTH=16).
//                Expected results are queued at acceptance and compared when
//                done pulses. rem checks follow ISQRT_REMAINDER_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_isqrt_seq;

    localparam int N8 = 4;

    typedef struct packed {
        logic [3:0] root;
        logic [4:0] rem;
        int         acc;
    } exp_t;

    logic        clk;
    logic        clear;
    logic        start;
    logic [7:0]  In;
    logic        ready;
    logic        done;
    logic [3:0]  root;
`ifdef ISQRT_REMAINDER_EN
    logic [4:0]  rem;
`endif

    logic        start16;
    logic [15:0] in16;
    logic        ready16;
    logic        done16;
    logic [7:0]  root16;
`ifdef ISQRT_REMAINDER_EN
    logic [8:0]  rem16;
`endif

    int   n_checks;
    int   n_errors;
    int   cyc;
    exp_t sb[$];
    exp_t mon_e;

    isqrt_seq #(.WIDTH(8)) u_dut (
        .clk   (clk),
        .clear (clear),
        .start (start),
        .In    (In),
        .ready (ready),
        .done  (done),
        .root  (root)
`ifdef ISQRT_REMAINDER_EN
        ,
        .rem   (rem)
`endif
    );

    isqrt_seq #(.WIDTH(16)) u_dut16 (
        .clk   (clk),
        .clear (clear),
        .start (start16),
        .In    (in16),
        .ready (ready16),
        .done  (done16),
        .root  (root16)
`ifdef ISQRT_REMAINDER_EN
        ,
        .rem   (rem16)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void ref_sqrt(input int x, output int q, output int r);
        q = 0;
        while ((q + 1) * (q + 1) <= x) q++;
        r = x - q * q;
    endfunction

    function automatic void push_exp(input logic [7:0] x);
        exp_t e;
        int   q;
        int   r;
        ref_sqrt(int'(x), q, r);
        e.root = q[3:0];
        e.rem  = r[4:0];
        e.acc  = cyc + 1;
        sb.push_back(e);
    endfunction

    // Scoreboard monitor: each done pulse pops one expectation
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("root", 32'(root), 32'(mon_e.root));
`ifdef ISQRT_REMAINDER_EN
                check("rem", 32'(rem), 32'(mon_e.rem));
`endif
                check("latency", 32'(cyc - mon_e.acc), 32'(N8));
            end
        end
    end

    // One full transaction on the 8-bit unit, with a stray start during RUN
    task automatic run_one(input logic [7:0] x);
        int g;
        g = 0;
        @(negedge clk);
        while (ready !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("idle_ready", 32'(ready), 32'd1);
        In    = x;
        start = 1'b1;
        push_exp(x);
        @(negedge clk);
        start = 1'b0;
        In    = ~x;
        check("busy_ready", 32'(ready), 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        g = 0;
        while (sb.size() != 0 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("completion", 32'(sb.size()), 32'd0);
        sb.delete();
        check("done_cycle_ready", 32'(ready), 32'd0);
        @(negedge clk);
        check("ready_after_done", 32'(ready), 32'd1);
        check("done_single_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        int g;
        int k;
        n_checks = 0;
        n_errors = 0;
        clear    = 1'b1;
        start    = 1'b0;
        In       = '0;
        start16  = 1'b0;
        in16     = '0;

        // Reset state
        repeat (3) @(negedge clk);
        clear = 1'b0;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_root", 32'(root), 32'd0);
`ifdef ISQRT_REMAINDER_EN
        check("rst_rem", 32'(rem), 32'd0);
`endif

        // Directed values with hand-derived results
        run_one(8'd200);
        check("root_200", 32'(root), 32'd14);
`ifdef ISQRT_REMAINDER_EN
        check("rem_200", 32'(rem), 32'd4);
`endif
        run_one(8'd255);
        check("root_255", 32'(root), 32'd15);
`ifdef ISQRT_REMAINDER_EN
        check("rem_255", 32'(rem), 32'd30);
`endif
        run_one(8'd196);
        check("root_196", 32'(root), 32'd14);
`ifdef ISQRT_REMAINDER_EN
        check("rem_196", 32'(rem), 32'd0);
`endif
        run_one(8'd1);
        check("root_1", 32'(root), 32'd1);
        run_one(8'd0);
        check("root_0", 32'(root), 32'd0);
`ifdef ISQRT_REMAINDER_EN
        check("rem_0", 32'(rem), 32'd0);
`endif

        // Outputs hold until the next completion
        run_one(8'd200);
        repeat (3) @(negedge clk);
        check("hold_root", 32'(root), 32'd14);

        // clear on the second RUN edge aborts and zeroes everything
        In    = 8'd200;
        start = 1'b1;
        push_exp(8'd200);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        sb.delete();
        @(negedge clk);
        clear = 1'b0;
        check("clr_ready", 32'(ready), 32'd1);
        check("clr_done", 32'(done), 32'd0);
        check("clr_root", 32'(root), 32'd0);
`ifdef ISQRT_REMAINDER_EN
        check("clr_rem", 32'(rem), 32'd0);
`endif
        run_one(8'd81);
        check("root_81", 32'(root), 32'd9);
`ifdef ISQRT_REMAINDER_EN
        check("rem_81", 32'(rem), 32'd0);
`endif

        // clear and start together: the start is dropped
        @(negedge clk);
        clear = 1'b1;
        start = 1'b1;
        In    = 8'd50;
        @(negedge clk);
        clear = 1'b0;
        start = 1'b0;
        check("clr_start_ready", 32'(ready), 32'd1);
        @(negedge clk);
        check("clr_start_idle", 32'(ready), 32'd1);

        // start held high with In changing every cycle
        start = 1'b1;
        for (int i = 0; i < 48; i++) begin
            In = 8'($urandom);
            if (ready === 1'b1) push_exp(In);
            @(negedge clk);
        end
        start = 1'b0;
        g = 0;
        while (sb.size() != 0 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("stream_drain", 32'(sb.size()), 32'd0);
        sb.delete();

        // Exhaustive sweep against the reference model
        for (int v = 0; v < 256; v++) begin
            run_one(8'(v));
        end

        // WIDTH=16 maximum radicand and latency
        @(negedge clk);
        check("w16_ready", 32'(ready16), 32'd1);
        in16    = 16'hFFFF;
        start16 = 1'b1;
        k = 0;
        while (k < 30) begin
            @(posedge clk);
            #1;
            start16 = 1'b0;
            in16    = 16'h0000;
            k++;
            if (done16 === 1'b1) break;
        end
        check("w16_latency", 32'(k - 1), 32'd8);
        check("w16_root", 32'(root16), 32'd255);
`ifdef ISQRT_REMAINDER_EN
        check("w16_rem", 32'(rem16), 32'd510);
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
